// File: rtl/spike_aer_encoder_pkg.sv
// Shared neuromorphic types: AER event word layout and a popcount helper
// also used by the neuron array's monitor logic.
package neuro_pkg;

    localparam int N_NEURONS      = 8;
    localparam int ADDR_W         = $clog2(N_NEURONS);
    localparam int TS_W           = 8;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [ADDR_W-1:0] addr;
    } aer_evt_t;

    function automatic logic [ADDR_W:0] popcount(input logic [N_NEURONS-1:0] v);
        logic [ADDR_W:0] n;
        n = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            n = n + (ADDR_W + 1)'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/spike_aer_encoder_if.sv
// Address-event output stream: valid/ready handshake carrying {ts, addr}.
interface spike_aer_encoder_if #(
    parameter int ADDR_W = 3,
    parameter int TS_W   = 8
) ();

    logic              evt_valid;
    logic              evt_ready;
    logic [ADDR_W-1:0] evt_addr;
    logic [TS_W-1:0]   evt_ts;

    modport master (
        output evt_valid,
        output evt_addr,
        output evt_ts,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_addr,
        input  evt_ts,
        output evt_ready
    );

endinterface

// File: rtl/spike_aer_encoder_fifo.sv
// Show-ahead FIFO of AER events: the head entry is visible on rd_data
// whenever the FIFO is non-empty; a write into a full FIFO is accepted
// only when a pop happens on the same edge.
module aer_event_fifo
    import neuro_pkg::*;
#(
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  aer_evt_t         wr_data,
    input  logic             rd_en,
    output aer_evt_t         rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    aer_evt_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign rd_fire = rd_en & ~empty;
    assign wr_fire = wr_en & (~full | rd_fire);
    assign count   = count_reg;

    // Storage is not reset; the empty gate below hides stale contents.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_fire) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/spike_aer_encoder.sv
// Serialises per-timestep spike vectors into AER events {timestamp, address},
// lowest address first, and accounts for events lost when a new vector arrives.
module spike_aer_encoder #(
    parameter  int N_NEURONS  = neuro_pkg::N_NEURONS,
    parameter  int ADDR_W     = neuro_pkg::ADDR_W,
    parameter  int TS_W       = neuro_pkg::TS_W,
    parameter  int FIFO_DEPTH = neuro_pkg::FIFO_DEPTH_DEF,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_NEURONS-1:0] spike_in,
    input  logic                 spike_strobe,
    input  logic                 tick,
    spike_aer_encoder_if.master  evt,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 busy,
    output logic                 overrun,
    output logic [7:0]           drop_count
);

    import neuro_pkg::*;

    logic [TS_W-1:0]      ts_cnt_reg;
    logic [N_NEURONS-1:0] pending_reg;
    logic [N_NEURONS-1:0] pending_next;
    logic [TS_W-1:0]      pend_ts_reg;
    logic                 overrun_reg;
    logic [7:0]           drop_count_reg;
    logic [7:0]           drop_count_next;
    logic [8:0]           drop_sum;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 can_write;
    aer_evt_t             fifo_wr_data;
    aer_evt_t             fifo_rd_data;

    logic [N_NEURONS-1:0] grant_onehot;
    logic [ADDR_W-1:0]    grant_idx;
    logic                 grant_valid;
    logic [N_NEURONS-1:0] leftover;
    logic [ADDR_W:0]      discarded;

    // A full FIFO still takes a grant when the head leaves on the same edge.
    assign fifo_pop    = ~fifo_empty & evt.evt_ready;
    assign can_write   = ~fifo_full | fifo_pop;
    assign grant_valid = (pending_reg != '0) & can_write;

    always_comb begin
        logic found;
        found        = 1'b0;
        grant_onehot = '0;
        grant_idx    = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (pending_reg[i] && !found) begin
                found           = 1'b1;
                grant_onehot[i] = 1'b1;
                grant_idx       = ADDR_W'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_leftover
            assign leftover[gi] = pending_reg[gi] & ~(grant_valid & grant_onehot[gi]);
        end
    endgenerate

    // Bits still waiting when a new vector lands are lost; the granted one is not.
    assign discarded       = spike_strobe ? popcount(leftover) : '0;
    assign drop_sum        = {1'b0, drop_count_reg} + 9'(discarded);
    assign drop_count_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    assign pending_next    = spike_strobe ? spike_in : leftover;

    assign fifo_wr_data.ts   = pend_ts_reg;
    assign fifo_wr_data.addr = grant_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt_reg     <= '0;
            pending_reg    <= '0;
            pend_ts_reg    <= '0;
            overrun_reg    <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            if (tick) begin
                ts_cnt_reg <= ts_cnt_reg + TS_W'(1);
            end
            if (spike_strobe) begin
                pend_ts_reg <= ts_cnt_reg;
            end
            if (discarded != '0) begin
                overrun_reg <= 1'b1;
            end
            pending_reg    <= pending_next;
            drop_count_reg <= drop_count_next;
        end
    end

    aer_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (grant_valid),
        .wr_data (fifo_wr_data),
        .rd_en   (evt.evt_ready),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign evt.evt_valid = ~fifo_empty;
    assign evt.evt_addr  = fifo_rd_data.addr;
    assign evt.evt_ts    = fifo_rd_data.ts;
    assign busy          = (pending_reg != '0);
    assign overrun       = overrun_reg;
    assign drop_count    = drop_count_reg;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Bench for spike_aer_encoder: vector table, directed corner sequences and a
// random run, all compared against a queue-based event model.
module tb_spike_aer_encoder;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] spike_in = 8'h00;
    logic       spike_strobe = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] fifo_count;
    logic       busy;
    logic       overrun;
    logic [7:0] drop_count;

    spike_aer_encoder_if #(.ADDR_W(3), .TS_W(8)) evt_if ();

    spike_aer_encoder #(
        .N_NEURONS  (8),
        .ADDR_W     (3),
        .TS_W       (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spike_in     (spike_in),
        .spike_strobe (spike_strobe),
        .tick         (tick),
        .evt          (evt_if),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .overrun      (overrun),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: timestamp, pending set, event queue, loss accounting.
    typedef struct {
        int ts;
        int addr;
    } ev_t;

    ev_t        mq[$];
    int         m_ts;
    int         m_pend_ts;
    int         m_drop;
    logic [7:0] m_pending;
    logic       m_ovr;

    typedef struct {
        logic       s;
        logic [7:0] sp;
        logic       t;
        logic       r;
        logic       e_valid;
        int         e_addr;
        int         e_ts;
        int         e_count;
        logic       e_busy;
    } vec_t;

    vec_t vecs[5];
    int   drain_addr[10];
    int   drain_ts[10];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ts      = 0;
        m_pend_ts = 0;
        m_drop    = 0;
        m_pending = 8'h00;
        m_ovr     = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic [7:0] sp, input logic t, input logic r);
        bit         pop;
        bit         space;
        int         g;
        int         disc;
        logic [7:0] rest;
        pop   = (mq.size() > 0) && r;
        space = (mq.size() < DEPTH) || pop;
        g     = -1;
        if (m_pending != 8'h00 && space) begin
            for (int i = 0; i < 8; i++) begin
                if (m_pending[i]) begin
                    g = i;
                    break;
                end
            end
        end
        rest = m_pending;
        if (g >= 0) rest[g] = 1'b0;
        if (s) begin
            disc   = $countones(rest);
            m_drop = (m_drop + disc > 255) ? 255 : m_drop + disc;
            if (disc > 0) m_ovr = 1'b1;
        end
        if (pop) void'(mq.pop_front());
        if (g >= 0) mq.push_back('{m_pend_ts, g});
        if (s) begin
            m_pending = sp;
            m_pend_ts = m_ts;
        end else begin
            m_pending = rest;
        end
        if (t) m_ts = (m_ts + 1) % 256;
    endtask

    task automatic compare_model(input string tag);
        bit has = (mq.size() > 0);
        chk({tag, " evt_valid"}, int'(evt_if.evt_valid), int'(has));
        chk({tag, " evt_addr"}, int'(evt_if.evt_addr), has ? mq[0].addr : 0);
        chk({tag, " evt_ts"}, int'(evt_if.evt_ts), has ? mq[0].ts : 0);
        chk({tag, " fifo_count"}, int'(fifo_count), mq.size());
        chk({tag, " busy"}, int'(busy), int'(m_pending != 8'h00));
        chk({tag, " overrun"}, int'(overrun), int'(m_ovr));
        chk({tag, " drop_count"}, int'(drop_count), m_drop);
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare.
    task automatic cycle(input logic s, input logic [7:0] sp, input logic t, input logic r,
                         input string tag);
        spike_strobe     = s;
        spike_in         = sp;
        tick             = t;
        evt_if.evt_ready = r;
        if (evt_if.evt_valid && r)
            $display("%s: pop ts=%0d addr=%0d", tag, evt_if.evt_ts, evt_if.evt_addr);
        @(posedge clk);
        model_step(s, sp, t, r);
        #1;
        compare_model(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        chk({tag, " evt_valid"}, int'(evt_if.evt_valid), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " fifo_count"}, int'(fifo_count), 0);
        chk({tag, " overrun"}, int'(overrun), 0);
        chk({tag, " drop_count"}, int'(drop_count), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        evt_if.evt_ready = 1'b0;
        model_reset();
        vecs[0] = '{1'b1, 8'hA4, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b1};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2, 0, 1, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5, 0, 1, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 7, 0, 1, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0};
        drain_addr = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        drain_ts   = '{3, 3, 3, 3, 3, 3, 3, 3, 4, 4};

        #12;
        compare_model("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic serialisation of 8'b1010_0100
        for (int i = 0; i < 5; i++) begin
            cycle(vecs[i].s, vecs[i].sp, vecs[i].t, vecs[i].r, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl valid", i), int'(evt_if.evt_valid), int'(vecs[i].e_valid));
            chk($sformatf("vec%0d tbl addr", i), int'(evt_if.evt_addr), vecs[i].e_addr);
            chk($sformatf("vec%0d tbl ts", i), int'(evt_if.evt_ts), vecs[i].e_ts);
            chk($sformatf("vec%0d tbl count", i), int'(fifo_count), vecs[i].e_count);
            chk($sformatf("vec%0d tbl busy", i), int'(busy), int'(vecs[i].e_busy));
        end
        chk("vec drop_count", int'(drop_count), 0);

        // Backpressure: fill at ts=3, hold a second vector at ts=4, then drain
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, "ts_adv");
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, "bp_strobe");
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, "bp_fill");
        chk("bp full count", int'(fifo_count), 8);
        chk("bp full busy", int'(busy), 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "bp_tick");
        cycle(1'b1, 8'h03, 1'b0, 1'b0, "bp_strobe2");
        cycle(1'b0, 8'h00, 1'b0, 1'b0, "bp_hold");
        chk("bp held busy", int'(busy), 1);
        chk("bp held count", int'(fifo_count), 8);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("drain%0d addr", i), int'(evt_if.evt_addr), drain_addr[i]);
            chk($sformatf("drain%0d ts", i), int'(evt_if.evt_ts), drain_ts[i]);
            cycle(1'b0, 8'h00, 1'b0, 1'b1, "bp_drain");
        end
        chk("drain empty count", int'(fifo_count), 0);
        chk("drain drop_count", int'(drop_count), 0);

        // Overrun: full FIFO, pending=03, new vector 8'h10 loses two events
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, "ov_strobe");
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, "ov_fill");
        cycle(1'b1, 8'h03, 1'b0, 1'b0, "ov_pend");
        cycle(1'b1, 8'h10, 1'b0, 1'b0, "ov_drop");
        chk("ov drop_count", int'(drop_count), 2);
        chk("ov overrun", int'(overrun), 1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, "ov_drain");
        chk("ov next valid", int'(evt_if.evt_valid), 1);
        chk("ov next addr", int'(evt_if.evt_addr), 4);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "ov_last");

        // Timestamp wrap and tick+strobe on one edge
        for (int i = 0; i < 300 && m_ts != 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, "ts_seek");
        for (int i = 0; i < 256; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, "ts_wrap");
        cycle(1'b1, 8'h01, 1'b1, 1'b1, "ts_both");
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "ts_evt");
        chk("wrap evt ts", int'(evt_if.evt_ts), 5);
        chk("wrap evt valid", int'(evt_if.evt_valid), 1);
        cycle(1'b1, 8'h02, 1'b0, 1'b1, "ts_next");
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "ts_next_evt");
        chk("post-tick evt ts", int'(evt_if.evt_ts), 6);
        chk("post-tick evt addr", int'(evt_if.evt_addr), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "ts_done");

        // Asynchronous reset mid-burst
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, "ar_strobe");
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, "ar_fill");
        chk("ar pre count", int'(fifo_count), 4);
        chk("ar pre busy", int'(busy), 1);
        async_reset("async_rst");

        // Drop counter saturation
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, "sat_strobe");
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, "sat_fill");
        for (int i = 0; i < 34; i++) cycle(1'b1, 8'hFF, 1'b0, 1'b0, "sat_ovr");
        chk("sat drop_count", int'(drop_count), 255);
        chk("sat overrun", int'(overrun), 1);
        @(negedge clk);
        async_reset("pre_rand_rst");

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 6, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
